// File: rtl/wptr_full.sv
// Write-domain half of an asynchronous FIFO: binary/Gray write pointers, RAM write
// address, two-flop read-pointer synchroniser and registered full/afull/level/overflow.
module wptr_full #(
    parameter int PTR_WIDTH    = 5,
    parameter int AFULL_THRESH = 28
) (
    input  logic                 wr_clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [PTR_WIDTH:0]   rptr_gray_i,
    output logic                 wr_full_o,
    output logic                 wr_afull_o,
    output logic [PTR_WIDTH-1:0] wr_addr_o,
    output logic [PTR_WIDTH:0]   wptr_gray_o,
    output logic [PTR_WIDTH:0]   wptr_bin_o,
    output logic [PTR_WIDTH:0]   wr_level_o,
    output logic                 wr_overflow_o
);

    localparam logic [PTR_WIDTH:0] AFULL_LVL = (PTR_WIDTH+1)'(AFULL_THRESH);

    logic [PTR_WIDTH:0]   r_rq1;
    logic [PTR_WIDTH:0]   r_rq2;
    logic [PTR_WIDTH:0]   r_wptr_bin;
    logic [PTR_WIDTH:0]   r_wptr_gray;
    logic [PTR_WIDTH-1:0] r_wr_addr;
    logic [PTR_WIDTH:0]   r_level;
    logic                 r_full;
    logic                 r_afull;
    logic                 r_ovf;

    logic                 w_accept;
    logic [PTR_WIDTH:0]   w_bin_nxt;
    logic [PTR_WIDTH:0]   w_gray_nxt;
    logic [PTR_WIDTH:0]   w_rbin;
    logic [PTR_WIDTH:0]   w_level_nxt;
    logic                 w_full_nxt;
    logic                 w_afull_nxt;
    logic                 w_ovf_nxt;

    assign w_accept   = wr_en_i & ~r_full;
    assign w_bin_nxt  = r_wptr_bin + {{PTR_WIDTH{1'b0}}, w_accept};
    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

    // Full when the next write pointer sits exactly one lap ahead of the synchronised
    // read pointer: in Gray code that is the read pointer with its top two bits inverted.
    assign w_full_nxt = (w_gray_nxt == {~r_rq2[PTR_WIDTH:PTR_WIDTH-1], r_rq2[PTR_WIDTH-2:0]});

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi <= PTR_WIDTH; gi++) begin : g_rbin
            assign w_rbin[gi] = ^r_rq2[PTR_WIDTH:gi];
        end
    endgenerate

    assign w_level_nxt = w_bin_nxt - w_rbin;
    assign w_afull_nxt = (w_level_nxt >= AFULL_LVL);
    assign w_ovf_nxt   = wr_en_i & r_full;

    always_ff @(posedge wr_clk_i) begin
        if (rst_i) begin
            r_rq1       <= '0;
            r_rq2       <= '0;
            r_wptr_bin  <= '0;
            r_wptr_gray <= '0;
            r_wr_addr   <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_afull     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_rq1       <= rptr_gray_i;
            r_rq2       <= r_rq1;
            r_wptr_bin  <= w_bin_nxt;
            r_wptr_gray <= w_gray_nxt;
            r_wr_addr   <= w_bin_nxt[PTR_WIDTH-1:0];
            r_level     <= w_level_nxt;
            r_full      <= w_full_nxt;
            r_afull     <= w_afull_nxt;
            r_ovf       <= w_ovf_nxt;
        end
    end

    assign wr_full_o     = r_full;
    assign wr_afull_o    = r_afull;
    assign wr_addr_o     = r_wr_addr;
    assign wptr_gray_o   = r_wptr_gray;
    assign wptr_bin_o    = r_wptr_bin;
    assign wr_level_o    = r_level;
    assign wr_overflow_o = r_ovf;

endmodule
